// File: rtl/addsub_serial_mag.sv
// rtl/addsub_serial_mag.sv - digit-serial add/subtract unit with sign-magnitude result
// Subtraction adds the inverted B with carry-in 1; a missing final carry means a<b and triggers a negate pass.
module addsub_serial_mag #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             busy
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG, S_DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc;
    logic               mode_r;
    logic               carry;
    logic [CNT_W-1:0]   digit_cnt;

    logic [DIGIT-1:0]       op_a;
    logic [DIGIT-1:0]       op_b;
    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_next;
    logic                   last_dig;

    // acc is a rotating shift register: each new digit enters at the top, so
    // after NDIG steps every digit is back in its natural position.
    always_comb begin
        op_a = a_r[DIGIT-1:0];
        op_b = b_r[DIGIT-1:0] ^ {DIGIT{mode_r}};
        if (state == S_NEG) begin
            op_a = ~acc[DIGIT-1:0];
            op_b = '0;
        end
        dsum     = {1'b0, op_a} + {1'b0, op_b} + {{DIGIT{1'b0}}, carry};
        acc_cat  = {dsum[DIGIT-1:0], acc};
        acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
        last_dig = (digit_cnt == CNT_W'(NDIG - 1));
    end

    assign result = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            flag      <= 1'b0;
            acc       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            mode_r    <= 1'b0;
            carry     <= 1'b0;
            digit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r       <= a;
                        b_r       <= b;
                        mode_r    <= mode;
                        carry     <= mode;
                        digit_cnt <= '0;
                        state     <= S_RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc       <= acc_next;
                    a_r       <= a_r >> DIGIT;
                    b_r       <= b_r >> DIGIT;
                    carry     <= dsum[DIGIT];
                    digit_cnt <= digit_cnt + CNT_W'(1);
                    if (last_dig) begin
                        digit_cnt <= '0;
                        if (!mode_r) begin
                            flag      <= dsum[DIGIT];
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end else if (dsum[DIGIT]) begin
                            flag      <= 1'b0;
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            flag  <= 1'b1;
                            carry <= 1'b1;
                            state <= S_NEG;
                        end
                    end
                end
                S_NEG: begin
                    acc       <= acc_next;
                    carry     <= dsum[DIGIT];
                    digit_cnt <= digit_cnt + CNT_W'(1);
                    if (last_dig) begin
                        digit_cnt <= '0;
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
